// File: rtl/store_buffer.sv
// store_buffer: formats MEM-stage stores into word-aligned writes with byte
// enables and queues them in a FIFO that drains to data memory via req/ack.
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      st_valid,
    input  logic [1:0]                st_size,
    input  logic [ADDR_W-1:0]         st_addr,
    input  logic [31:0]               st_data,
    output logic                      st_ready,
    output logic                      misalign,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [31:0]               mem_wdata,
    output logic [3:0]                mem_be,
    input  logic                      mem_ack,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_NONE = 2'b11;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
    } entry_t;

    entry_t           fifo_mem [DEPTH];
    entry_t           new_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             aligned;
    logic             full;
    logic             store_op;
    logic             push;
    logic             pop;
    logic             misalign_nxt;
    logic [1:0]       lane;

    // Store formatting: lane replication, byte enables and alignment check
    always_comb begin
        lane            = st_addr[1:0];
        aligned         = 1'b0;
        new_entry.addr  = {st_addr[ADDR_W-1:2], 2'b00};
        new_entry.wdata = st_data;
        new_entry.be    = 4'b0000;
        case (st_size)
            SIZE_WORD: begin
                aligned         = (lane == 2'b00);
                new_entry.be    = 4'b1111;
                new_entry.wdata = st_data;
            end
            SIZE_BYTE: begin
                aligned         = 1'b1;
                new_entry.be    = 4'(4'b0001 << lane);
                new_entry.wdata = {4{st_data[7:0]}};
            end
            SIZE_HALF: begin
                aligned         = ~lane[0];
                new_entry.be    = lane[1] ? 4'b1100 : 4'b0011;
                new_entry.wdata = {2{st_data[15:0]}};
            end
            default: begin
                aligned = 1'b0;
            end
        endcase
    end

    // Handshake and status decode from registered state
    always_comb begin
        full         = (count == CNT_W'(DEPTH));
        empty        = (count == '0);
        st_ready     = ~full;
        mem_req      = ~empty;
        store_op     = (st_size != SIZE_NONE);
        push         = st_valid && st_ready && store_op && aligned;
        misalign_nxt = st_valid && st_ready && store_op && !aligned;
        pop          = mem_req && mem_ack;
        head         = fifo_mem[rd_ptr];
        mem_addr     = mem_req ? head.addr  : '0;
        mem_wdata    = mem_req ? head.wdata : '0;
        mem_be       = mem_req ? head.be    : '0;
    end

    // Entry storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= new_entry;
        end
    end

    // Pointers, occupancy and misalign pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            misalign <= 1'b0;
        end else begin
            misalign <= misalign_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule
